interrupt_controller: RTL and testbench

Sequencing block directly upstream of the program counter. It synchronises two external interrupt request lines, latches pending requests, and arbitrates INT0 over INT1. At instruction boundaries it drives the program counter's `PC_LD_INT0X`, `PC_LD_INT1X` and `PC_NEXTX` controls to:
- save the return address and vector to `INTV0` (0x0004) or `INTV1` (0x0008) on entry;
- restore the saved address on RETI.

---
 rtl/interrupt_controller_pkg.sv | 24 ++
 rtl/interrupt_controller_sync.sv | 27 ++
 rtl/interrupt_controller.sv | 120 ++++++++++++
 tb/tb_interrupt_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller and the program counter it steers:
// next-address select encodings, vector addresses and the SEL decision encoding.
package interrupt_controller_pkg;

  localparam int PC_NEXTX_W = 3;

  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_NEXT  = 3'd0;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV0 = 3'd1;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV1 = 3'd2;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR0 = 3'd3;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR1 = 3'd4;

  localparam logic [15:0] INTV0 = 16'h0004;
  localparam logic [15:0] INTV1 = 16'h0008;

  typedef enum logic [2:0] {
    INT_SEL_NONE = 3'd0,
    INT_SEL_ENT0 = 3'd1,
    INT_SEL_ENT1 = 3'd2,
    INT_SEL_RET0 = 3'd3,
    INT_SEL_RET1 = 3'd4
  } int_sel_e;

endpackage

// File: rtl/interrupt_controller_sync.sv
// Request synchroniser (SYNC_STAGES flops, minimum 2) followed by a previous-value
// flop; o_edge is a one-cycle pulse on each synchronised rising edge.
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_req,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Two-level interrupt sequencer: latches pending requests, decides entry/return on
// each DECODE and steers the program counter during the following FETCH.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FETCH,
  input  logic                  DECODE,
  input  logic                  INT0_REQ,
  input  logic                  INT1_REQ,
  input  logic                  EI,
  input  logic                  DI,
  input  logic                  RETI,
  output logic                  PC_LD_INT0X,
  output logic                  PC_LD_INT1X,
  output logic [PC_NEXTX_W-1:0] PC_NEXTX,
  output logic [1:0]            INT_PENDING,
  output logic [1:0]            INT_ACTIVE,
  output logic                  GIE
);

  logic [1:0] w_req;
  logic [1:0] w_edge;
  logic [1:0] w_act_set;
  logic [1:0] w_act_clr;
  logic [1:0] r_pending;
  logic [1:0] r_active;
  logic       r_gie;
  int_sel_e   r_sel;
  int_sel_e   w_sel_next;

  assign w_req = {INT1_REQ, INT0_REQ};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .i_req  (w_req[gi]),
      .o_edge (w_edge[gi])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_sel     <= INT_SEL_NONE;
      r_pending <= '0;
      r_active  <= '0;
      r_gie     <= 1'b0;
    end else begin
      r_sel     <= w_sel_next;
      // a new edge wins over the entry commit clearing the same bit
      r_pending <= (r_pending & ~w_act_set) | w_edge;
      r_active  <= (r_active | w_act_set) & ~w_act_clr;
      if (DECODE && DI) begin
        r_gie <= 1'b0;
      end else if (DECODE && EI) begin
        r_gie <= 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_next = r_sel;
    if (DECODE) begin
      if (RETI) begin
        if (r_active[0])      w_sel_next = INT_SEL_RET0;
        else if (r_active[1]) w_sel_next = INT_SEL_RET1;
        else                  w_sel_next = INT_SEL_NONE;
      end else if (r_gie && r_pending[0] && !r_active[0]) begin
        w_sel_next = INT_SEL_ENT0;
      end else if (r_gie && r_pending[1] && r_active == 2'b00) begin
        w_sel_next = INT_SEL_ENT1;
      end else begin
        w_sel_next = INT_SEL_NONE;
      end
    end else if (FETCH) begin
      w_sel_next = INT_SEL_NONE;
    end
  end

  always_comb begin
    PC_LD_INT0X = 1'b0;
    PC_LD_INT1X = 1'b0;
    PC_NEXTX    = PC_NEXTX_NEXT;
    w_act_set   = 2'b00;
    w_act_clr   = 2'b00;
    if (FETCH) begin
      case (r_sel)
        INT_SEL_ENT0: begin
          PC_LD_INT0X  = 1'b1;
          PC_NEXTX     = PC_NEXTX_INTV0;
          w_act_set[0] = 1'b1;
        end
        INT_SEL_ENT1: begin
          PC_LD_INT1X  = 1'b1;
          PC_NEXTX     = PC_NEXTX_INTV1;
          w_act_set[1] = 1'b1;
        end
        INT_SEL_RET0: begin
          PC_NEXTX     = PC_NEXTX_INTR0;
          w_act_clr[0] = 1'b1;
        end
        INT_SEL_RET1: begin
          PC_NEXTX     = PC_NEXTX_INTR1;
          w_act_clr[1] = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign INT_PENDING = r_pending;
  assign INT_ACTIVE  = r_active;
  assign GIE         = r_gie;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller, with a small program counter model that
// follows the PC controls so vector and return addresses can be checked.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       FETCH = 1'b0;
  logic       DECODE = 1'b0;
  logic       INT0_REQ = 1'b0;
  logic       INT1_REQ = 1'b0;
  logic       EI = 1'b0;
  logic       DI = 1'b0;
  logic       RETI = 1'b0;
  logic       PC_LD_INT0X;
  logic       PC_LD_INT1X;
  logic [2:0] PC_NEXTX;
  logic [1:0] INT_PENDING;
  logic [1:0] INT_ACTIVE;
  logic       GIE;

  int n_tests = 0;
  int n_fail  = 0;

  logic        obs_ld0, obs_ld1;
  logic [2:0]  obs_nextx;
  logic [15:0] pc = 16'h0000;
  logic [15:0] intr0 = 16'h0000;
  logic [15:0] intr1 = 16'h0000;
  logic        pc_set = 1'b0;
  logic [15:0] pc_set_val = 16'h0000;

  interrupt_controller #(.SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .FETCH      (FETCH),
    .DECODE     (DECODE),
    .INT0_REQ   (INT0_REQ),
    .INT1_REQ   (INT1_REQ),
    .EI         (EI),
    .DI         (DI),
    .RETI       (RETI),
    .PC_LD_INT0X(PC_LD_INT0X),
    .PC_LD_INT1X(PC_LD_INT1X),
    .PC_NEXTX   (PC_NEXTX),
    .INT_PENDING(INT_PENDING),
    .INT_ACTIVE (INT_ACTIVE),
    .GIE        (GIE)
  );

  always #5 CLK = ~CLK;

  // program counter model: 2-byte instructions, SUM = pc + 2
  always @(posedge CLK) begin
    if (pc_set) begin
      pc <= pc_set_val;
    end else if (FETCH) begin
      case (PC_NEXTX)
        PC_NEXTX_INTV0: pc <= INTV0;
        PC_NEXTX_INTV1: pc <= INTV1;
        PC_NEXTX_INTR0: pc <= intr0;
        PC_NEXTX_INTR1: pc <= intr1;
        default:        pc <= pc + 16'd2;
      endcase
      if (PC_LD_INT0X) intr0 <= pc + 16'd2;
      if (PC_LD_INT1X) intr1 <= pc + 16'd2;
    end
  end

  // drive one clock cycle, capture outputs mid-cycle, return 1 time unit after the edge
  task automatic cycle(input logic f, input logic d, input logic ei, input logic di, input logic reti);
    FETCH = f; DECODE = d; EI = ei; DI = di; RETI = reti;
    #3;
    obs_ld0 = PC_LD_INT0X;
    obs_ld1 = PC_LD_INT1X;
    obs_nextx = PC_NEXTX;
    @(posedge CLK); #1;
    FETCH = 1'b0; DECODE = 1'b0; EI = 1'b0; DI = 1'b0; RETI = 1'b0;
  endtask

  task automatic instr(input logic ei, input logic di, input logic reti);
    cycle(1'b0, 1'b1, ei, di, reti);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] instr ei=%b di=%b reti=%b -> ld0=%b ld1=%b nextx=%0d pend=%b act=%b gie=%b pc=%h",
             ei, di, reti, obs_ld0, obs_ld1, obs_nextx, INT_PENDING, INT_ACTIVE, GIE, pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; INT0_REQ = 1'b0; INT1_REQ = 1'b0;
    idle(2);
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; INT0_REQ = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b0 || obs_ld1 !== 1'b0) begin n_fail++; $display("FAIL reset_ld: got %b%b want 00", obs_ld1, obs_ld0); end
    n_tests++; if (obs_nextx !== PC_NEXTX_NEXT) begin n_fail++; $display("FAIL reset_nextx: got %0d want %0d", obs_nextx, PC_NEXTX_NEXT); end
    n_tests++; if ({INT_PENDING, INT_ACTIVE, GIE} !== 5'b0) begin n_fail++; $display("FAIL reset_state: got pend=%b act=%b gie=%b want 0", INT_PENDING, INT_ACTIVE, GIE); end
    RESET_N = 1'b1;
    idle(2);
    n_tests++; if (INT_PENDING !== 2'b00) begin n_fail++; $display("FAIL latency_early: got pend=%b want 00", INT_PENDING); end
    idle(1);
    n_tests++; if (INT_PENDING !== 2'b01) begin n_fail++; $display("FAIL latency_exact: got pend=%b want 01", INT_PENDING); end
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b0 || obs_nextx !== PC_NEXTX_NEXT) begin n_fail++; $display("FAIL reset_no_entry: got ld0=%b nextx=%0d want 0/%0d", obs_ld0, obs_nextx, PC_NEXTX_NEXT); end
    n_tests++; if (INT_PENDING !== 2'b01 || INT_ACTIVE !== 2'b00) begin n_fail++; $display("FAIL reset_no_entry_state: got pend=%b act=%b want 01/00", INT_PENDING, INT_ACTIVE); end
    INT0_REQ = 1'b0;
  endtask

  task automatic test_reset_mid_entry();
    do_reset();
    instr(1'b1, 1'b0, 1'b0);
    INT0_REQ = 1'b1; idle(4); INT0_REQ = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if ({INT_PENDING, INT_ACTIVE, GIE} !== 5'b0) begin n_fail++; $display("FAIL midreset_state: got pend=%b act=%b gie=%b want 0", INT_PENDING, INT_ACTIVE, GIE); end
    RESET_N = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b0 || obs_nextx !== PC_NEXTX_NEXT) begin n_fail++; $display("FAIL midreset_out: got ld0=%b nextx=%0d want 0/%0d", obs_ld0, obs_nextx, PC_NEXTX_NEXT); end
  endtask

  task automatic test_basic_entry();
    do_reset();
    instr(1'b1, 1'b0, 1'b0);
    n_tests++; if (GIE !== 1'b1) begin n_fail++; $display("FAIL basic_gie: got %b want 1", GIE); end
    INT1_REQ = 1'b1; idle(4); INT1_REQ = 1'b0;
    n_tests++; if (INT_PENDING !== 2'b10) begin n_fail++; $display("FAIL basic_pend: got %b want 10", INT_PENDING); end
    pc_set = 1'b1; pc_set_val = 16'h0100; idle(1); pc_set = 1'b0;
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld1 !== 1'b1 || obs_ld0 !== 1'b0) begin n_fail++; $display("FAIL basic_ld: got ld1=%b ld0=%b want 1/0", obs_ld1, obs_ld0); end
    n_tests++; if (obs_nextx !== PC_NEXTX_INTV1) begin n_fail++; $display("FAIL basic_nextx: got %0d want %0d", obs_nextx, PC_NEXTX_INTV1); end
    n_tests++; if (pc !== 16'h0008 || intr1 !== 16'h0102) begin n_fail++; $display("FAIL basic_pc: got pc=%h intr1=%h want 0008/0102", pc, intr1); end
    n_tests++; if (INT_ACTIVE !== 2'b10 || INT_PENDING !== 2'b00) begin n_fail++; $display("FAIL basic_state: got act=%b pend=%b want 10/00", INT_ACTIVE, INT_PENDING); end
  endtask

  task automatic test_preemption();
    do_reset();
    instr(1'b1, 1'b0, 1'b0);
    INT1_REQ = 1'b1; idle(4); INT1_REQ = 1'b0;
    instr(1'b0, 1'b0, 1'b0);
    INT0_REQ = 1'b1; idle(4); INT0_REQ = 1'b0;
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b1 || obs_nextx !== PC_NEXTX_INTV0) begin n_fail++; $display("FAIL preempt_entry: got ld0=%b nextx=%0d want 1/%0d", obs_ld0, obs_nextx, PC_NEXTX_INTV0); end
    n_tests++; if (INT_ACTIVE !== 2'b11 || pc !== 16'h0004) begin n_fail++; $display("FAIL preempt_state: got act=%b pc=%h want 11/0004", INT_ACTIVE, pc); end
    instr(1'b0, 1'b0, 1'b1);
    n_tests++; if (obs_nextx !== PC_NEXTX_INTR0 || INT_ACTIVE !== 2'b10) begin n_fail++; $display("FAIL preempt_ret0: got nextx=%0d act=%b want %0d/10", obs_nextx, INT_ACTIVE, PC_NEXTX_INTR0); end
    instr(1'b0, 1'b0, 1'b1);
    n_tests++; if (obs_nextx !== PC_NEXTX_INTR1 || INT_ACTIVE !== 2'b00) begin n_fail++; $display("FAIL preempt_ret1: got nextx=%0d act=%b want %0d/00", obs_nextx, INT_ACTIVE, PC_NEXTX_INTR1); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    instr(1'b1, 1'b0, 1'b0);
    INT0_REQ = 1'b1; INT1_REQ = 1'b1; idle(4); INT0_REQ = 1'b0; INT1_REQ = 1'b0;
    n_tests++; if (INT_PENDING !== 2'b11) begin n_fail++; $display("FAIL simul_pend: got %b want 11", INT_PENDING); end
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b1 || obs_ld1 !== 1'b0 || obs_nextx !== PC_NEXTX_INTV0) begin n_fail++; $display("FAIL simul_first: got ld0=%b ld1=%b nextx=%0d want 1/0/%0d", obs_ld0, obs_ld1, obs_nextx, PC_NEXTX_INTV0); end
    n_tests++; if (INT_ACTIVE !== 2'b01 || INT_PENDING !== 2'b10) begin n_fail++; $display("FAIL simul_state: got act=%b pend=%b want 01/10", INT_ACTIVE, INT_PENDING); end
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld1 !== 1'b0 || obs_nextx !== PC_NEXTX_NEXT) begin n_fail++; $display("FAIL simul_blocked: got ld1=%b nextx=%0d want 0/%0d", obs_ld1, obs_nextx, PC_NEXTX_NEXT); end
    // RETI decode, then a strobe-free gap cycle: outputs must stay idle until FETCH
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_nextx !== PC_NEXTX_NEXT) begin n_fail++; $display("FAIL gap_nextx: got %0d want %0d", obs_nextx, PC_NEXTX_NEXT); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_nextx !== PC_NEXTX_INTR0 || INT_ACTIVE !== 2'b00) begin n_fail++; $display("FAIL simul_ret0: got nextx=%0d act=%b want %0d/00", obs_nextx, INT_ACTIVE, PC_NEXTX_INTR0); end
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld1 !== 1'b1 || INT_ACTIVE !== 2'b10) begin n_fail++; $display("FAIL simul_second: got ld1=%b act=%b want 1/10", obs_ld1, INT_ACTIVE); end
  endtask

  task automatic test_reti_vs_pending();
    do_reset();
    instr(1'b1, 1'b0, 1'b0);
    INT1_REQ = 1'b1; idle(4); INT1_REQ = 1'b0;
    instr(1'b0, 1'b0, 1'b0);
    INT1_REQ = 1'b1; idle(4); INT1_REQ = 1'b0;
    n_tests++; if (INT_PENDING !== 2'b10 || INT_ACTIVE !== 2'b10) begin n_fail++; $display("FAIL repend_state: got pend=%b act=%b want 10/10", INT_PENDING, INT_ACTIVE); end
    instr(1'b0, 1'b0, 1'b1);
    n_tests++; if (obs_nextx !== PC_NEXTX_INTR1 || obs_ld1 !== 1'b0) begin n_fail++; $display("FAIL reti_first: got nextx=%0d ld1=%b want %0d/0", obs_nextx, obs_ld1, PC_NEXTX_INTR1); end
    n_tests++; if (INT_PENDING !== 2'b10 || INT_ACTIVE !== 2'b00) begin n_fail++; $display("FAIL reti_first_state: got pend=%b act=%b want 10/00", INT_PENDING, INT_ACTIVE); end
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld1 !== 1'b1 || obs_nextx !== PC_NEXTX_INTV1) begin n_fail++; $display("FAIL reti_then_ent: got ld1=%b nextx=%0d want 1/%0d", obs_ld1, obs_nextx, PC_NEXTX_INTV1); end
    instr(1'b0, 1'b0, 1'b1);
    instr(1'b0, 1'b0, 1'b1);
    n_tests++; if (obs_nextx !== PC_NEXTX_NEXT || obs_ld0 !== 1'b0 || obs_ld1 !== 1'b0) begin n_fail++; $display("FAIL reti_idle: got nextx=%0d ld=%b%b want %0d/00", obs_nextx, obs_ld1, obs_ld0, PC_NEXTX_NEXT); end
  endtask

  task automatic test_gie();
    do_reset();
    instr(1'b1, 1'b1, 1'b0);
    n_tests++; if (GIE !== 1'b0) begin n_fail++; $display("FAIL gie_both: got %b want 0", GIE); end
    instr(1'b1, 1'b0, 1'b0);
    n_tests++; if (GIE !== 1'b1) begin n_fail++; $display("FAIL gie_set: got %b want 1", GIE); end
    instr(1'b0, 1'b1, 1'b0);
    n_tests++; if (GIE !== 1'b0) begin n_fail++; $display("FAIL gie_clear: got %b want 0", GIE); end
    INT0_REQ = 1'b1; idle(4); INT0_REQ = 1'b0;
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b0 || INT_PENDING !== 2'b01) begin n_fail++; $display("FAIL gie_blocked: got ld0=%b pend=%b want 0/01", obs_ld0, INT_PENDING); end
    instr(1'b1, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b0) begin n_fail++; $display("FAIL gie_ei_same: got ld0=%b want 0", obs_ld0); end
    instr(1'b0, 1'b0, 1'b0);
    n_tests++; if (obs_ld0 !== 1'b1 || INT_ACTIVE !== 2'b01 || INT_PENDING !== 2'b00) begin n_fail++; $display("FAIL gie_entry: got ld0=%b act=%b pend=%b want 1/01/00", obs_ld0, INT_ACTIVE, INT_PENDING); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_entry();
    test_basic_entry();
    test_preemption();
    test_simultaneous();
    test_reti_vs_pending();
    test_gie();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
